buzzer_arbiter: RTL and testbench

BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

---
 rtl/buzzer_arbiter_if.sv | 24 ++
 rtl/buzzer_arbiter.sv | 164 ++++++++++++++++
 tb/tb_buzzer_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/buzzer_arbiter_if.sv
// Requester/buzzer signal bundle for buzzer_arbiter.
// The master side drives requests; the slave side (the arbiter) drives the buzzer outputs.
interface buzzer_arbiter_if;
  logic [2:0] en;
  logic [2:0] req;
  logic [3:0] note0;
  logic [3:0] note1;
  logic [3:0] note2;
  logic [3:0] note_out;
  logic       note_on;
  logic [2:0] grant;
  logic [2:0] done;
  logic       busy;

  modport master (
    output en, req, note0, note1, note2,
    input  note_out, note_on, grant, done, busy
  );

  modport slave (
    input  en, req, note0, note1, note2,
    output note_out, note_on, grant, done, busy
  );
endinterface

// File: rtl/buzzer_arbiter.sv
// Fixed-priority (0 > 1 > 2) buzzer arbiter with minimum on-time before preemption
// and a fixed silent gap between consecutive grants. All outputs are registered.
module buzzer_arbiter #(
  parameter int GAP_CYCLES = 1000,
  parameter int MIN_ON     = 5000
) (
  input  logic              clk,
  input  logic              rst,
  buzzer_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [15:0] MIN_ON_C   = 16'(MIN_ON);
  localparam logic [15:0] GAP_LAST_C = 16'(GAP_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [1:0]  owner_reg, owner_next;
  logic [3:0]  note_out_reg, note_out_next;
  logic        note_on_reg, note_on_next;
  logic [2:0]  grant_reg, grant_next;
  logic [2:0]  done_reg, done_next;
  logic        busy_reg, busy_next;
  logic [15:0] on_cnt_reg, on_cnt_next;
  logic [15:0] gap_cnt_reg, gap_cnt_next;

  logic [2:0]  active;
  logic [1:0]  win_idx;
  logic [2:0]  win_onehot;
  logic [3:0]  win_note;
  logic [3:0]  owner_note;
  logic        owner_lost;
  logic        higher_active;
  logic        release_now;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_active
      assign active[gi] = bus.req[gi] & bus.en[gi];
    end
  endgenerate

  always_comb begin
    win_idx    = 2'd0;
    win_onehot = 3'b000;
    win_note   = bus.note0;
    if (active[0]) begin
      win_idx    = 2'd0;
      win_onehot = 3'b001;
      win_note   = bus.note0;
    end else if (active[1]) begin
      win_idx    = 2'd1;
      win_onehot = 3'b010;
      win_note   = bus.note1;
    end else if (active[2]) begin
      win_idx    = 2'd2;
      win_onehot = 3'b100;
      win_note   = bus.note2;
    end
  end

  always_comb begin
    case (owner_reg)
      2'd0:    owner_note = bus.note0;
      2'd1:    owner_note = bus.note1;
      default: owner_note = bus.note2;
    endcase
  end

  // For a one-hot owner, grant-1 is exactly the mask of higher-priority requesters.
  assign owner_lost    = |(grant_reg & ~active);
  assign higher_active = |(active & (grant_reg - 3'd1));
  assign release_now   = owner_lost
                       | (owner_note != note_out_reg)
                       | (higher_active && (on_cnt_reg == MIN_ON_C));

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    note_out_next = note_out_reg;
    note_on_next  = note_on_reg;
    grant_next    = grant_reg;
    done_next     = 3'b000;
    on_cnt_next   = on_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;

    case (state_reg)
      IDLE: begin
        note_on_next = 1'b0;
        grant_next   = 3'b000;
        if (|active) begin
          state_next    = ON;
          owner_next    = win_idx;
          note_out_next = win_note;
          note_on_next  = 1'b1;
          grant_next    = win_onehot;
          on_cnt_next   = 16'd0;
        end
      end
      ON: begin
        if (release_now) begin
          state_next   = GAP;
          note_on_next = 1'b0;
          grant_next   = 3'b000;
          done_next    = grant_reg;
          gap_cnt_next = 16'd0;
        end else if (on_cnt_reg != MIN_ON_C) begin
          on_cnt_next = on_cnt_reg + 16'd1;
        end
      end
      GAP: begin
        note_on_next = 1'b0;
        grant_next   = 3'b000;
        if (gap_cnt_reg >= GAP_LAST_C) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 16'd1;
        end
      end
      default: begin
        state_next   = IDLE;
        note_on_next = 1'b0;
        grant_next   = 3'b000;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      owner_reg    <= 2'd0;
      note_out_reg <= 4'd0;
      note_on_reg  <= 1'b0;
      grant_reg    <= 3'b000;
      done_reg     <= 3'b000;
      busy_reg     <= 1'b0;
      on_cnt_reg   <= 16'd0;
      gap_cnt_reg  <= 16'd0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      note_out_reg <= note_out_next;
      note_on_reg  <= note_on_next;
      grant_reg    <= grant_next;
      done_reg     <= done_next;
      busy_reg     <= busy_next;
      on_cnt_reg   <= on_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
    end
  end

  assign bus.note_out = note_out_reg;
  assign bus.note_on  = note_on_reg;
  assign bus.grant    = grant_reg;
  assign bus.done     = done_reg;
  assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter with GAP_CYCLES=4, MIN_ON=8.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_buzzer_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  buzzer_arbiter_if bus ();

  buzzer_arbiter #(
    .GAP_CYCLES (4),
    .MIN_ON     (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h t=%0t", tag, got, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b0;
    bus.en    = 3'b000;
    bus.req   = 3'b000;
    bus.note0 = 4'd0;
    bus.note1 = 4'd0;
    bus.note2 = 4'd0;
    tick(2);
    check("rst_note_on",  32'(bus.note_on),  32'd0);
    check("rst_grant",    32'(bus.grant),    32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_note_out", 32'(bus.note_out), 32'd0);
    check("rst_done",     32'(bus.done),     32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(1);

    // single grant, cycle 0 -> 1
    bus.en    = 3'b111;
    bus.note1 = 4'd5;
    bus.req   = 3'b010;
    tick(1);
    check("s1_grant",    32'(bus.grant),    32'b010);
    check("s1_note_out", 32'(bus.note_out), 32'd5);
    check("s1_note_on",  32'(bus.note_on),  32'd1);
    check("s1_busy",     32'(bus.busy),     32'd1);
    tick(9);
    check("s1_held_c10", 32'(bus.grant),    32'b010);
    bus.req = 3'b000;
    tick(1);
    check("rel_note_on", 32'(bus.note_on),  32'd0);
    check("rel_grant",   32'(bus.grant),    32'd0);
    check("rel_done",    32'(bus.done),     32'b010);
    check("rel_busy",    32'(bus.busy),     32'd1);
    tick(1);
    check("rel_done_1c", 32'(bus.done),     32'd0);
    tick(2);
    check("gap_busy_14", 32'(bus.busy),     32'd1);
    tick(1);
    check("idle_busy15", 32'(bus.busy),     32'd0);
    check("idle_note",   32'(bus.note_out), 32'd5);

    // retrigger on owner 2
    bus.note2 = 4'd3;
    bus.req   = 3'b100;
    tick(1);
    check("rt_grant",    32'(bus.grant),    32'b100);
    check("rt_note3",    32'(bus.note_out), 32'd3);
    tick(2);
    bus.note2 = 4'd7;
    tick(1);
    check("rt_rel_on",   32'(bus.note_on),  32'd0);
    check("rt_done",     32'(bus.done),     32'b100);
    tick(4);
    check("rt_m5_on",    32'(bus.note_on),  32'd0);
    check("rt_m5_grant", 32'(bus.grant),    32'd0);
    tick(1);
    check("rt_m6_on",    32'(bus.note_on),  32'd1);
    check("rt_m6_note",  32'(bus.note_out), 32'd7);

    bus.req = 3'b000;
    tick(5);
    check("rt_idle",     32'(bus.busy),     32'd0);

    // preemption timing: owner 1 at cycle 1, req0 at cycle 3
    bus.note1 = 4'd2;
    bus.req   = 3'b010;
    tick(1);
    check("pe_grant1",   32'(bus.grant),    32'b010);
    tick(2);
    bus.note0 = 4'd9;
    bus.req   = 3'b011;
    tick(5);
    check("pe_c8_grant", 32'(bus.grant),    32'b010);
    tick(1);
    check("pe_c9_grant", 32'(bus.grant),    32'b010);
    check("pe_c9_on",    32'(bus.note_on),  32'd1);
    tick(1);
    check("pe_c10_on",   32'(bus.note_on),  32'd0);
    check("pe_c10_done", 32'(bus.done),     32'b010);
    tick(4);
    check("pe_c14_gr",   32'(bus.grant),    32'd0);
    tick(1);
    check("pe_c15_gr",   32'(bus.grant),    32'b001);
    check("pe_c15_note", 32'(bus.note_out), 32'd9);

    // lower priority never preempts; en0 drop releases
    bus.req = 3'b101;
    tick(100);
    check("lp_grant",    32'(bus.grant),    32'b001);
    check("lp_on",       32'(bus.note_on),  32'd1);
    check("lp_note",     32'(bus.note_out), 32'd9);
    bus.en = 3'b110;
    tick(1);
    check("en_rel_on",   32'(bus.note_on),  32'd0);
    check("en_done",     32'(bus.done),     32'b001);
    tick(4);
    check("en_gap_gr",   32'(bus.grant),    32'd0);
    tick(1);
    check("en_grant2",   32'(bus.grant),    32'b100);
    check("en_note7",    32'(bus.note_out), 32'd7);

    // asynchronous reset mid-ON, between clock edges
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ar_note_on",  32'(bus.note_on),  32'd0);
    check("ar_grant",    32'(bus.grant),    32'd0);
    check("ar_busy",     32'(bus.busy),     32'd0);
    check("ar_note_out", 32'(bus.note_out), 32'd0);
    tick(2);
    check("ar_hold_gr",  32'(bus.grant),    32'd0);
    check("ar_hold_dn",  32'(bus.done),     32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ar_rel_gr",   32'(bus.grant),    32'd0);
    tick(1);
    check("ar_regrant",  32'(bus.grant),    32'b100);
    check("ar_no_done",  32'(bus.done),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
